shift_seq_ctrl: RTL and testbench

// - Sequencer and arbiter in front of one 8-bit shift_reg2 instance. Two requesters submit
//   {op, count, data} commands; a round-robin arbiter grants one, the block loads the data,

---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/shift_reg2.sv | 34 +++
 rtl/shift_seq_rr_arb.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 110 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared op codes, FSM state type and op sanitising helper for the shift sequencer.
package shift_seq_pkg;

  localparam logic [2:0] DIR_LOAD = 3'b000;
  localparam logic [2:0] DIR_SHL  = 3'b001;
  localparam logic [2:0] DIR_SHR  = 3'b010;
  localparam logic [2:0] DIR_ROL  = 3'b011;
  localparam logic [2:0] DIR_ROR  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  // Unknown op codes collapse to a plain load so the shifter never sees them.
  function automatic logic [2:0] sanitize_op(input logic [2:0] op);
    sanitize_op = (op <= DIR_ROR) ? op : DIR_LOAD;
  endfunction

endpackage

// File: rtl/shift_reg2.sv
// 8-bit load/shift/rotate register driven by the sequencer; holds when not enabled.
module shift_reg2
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       shift_direction,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (enable) begin
      case (shift_direction)
        DIR_LOAD: data_q <= data_in;
        DIR_SHL:  data_q <= {data_q[WIDTH-2:0], 1'b0};
        DIR_SHR:  data_q <= {1'b0, data_q[WIDTH-1:1]};
        DIR_ROL:  data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        DIR_ROR:  data_q <= {data_q[0], data_q[WIDTH-1:1]};
        default:  data_q <= data_q;
      endcase
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/shift_seq_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves to the non-granted side on advance.
module shift_seq_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (ptr_q == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
    ptr_d = ptr_q;
    if (advance) ptr_d = gnt[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Arbitrates two command sources onto one shift_reg2: load, shift `cnt` times, return result.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_op,
  input  logic [2*CNT_W-1:0] req_cnt,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy,
  output logic               sr_enable,
  output logic [2:0]         sr_dir,
  output logic [WIDTH-1:0]   sr_data_in,
  input  logic [WIDTH-1:0]   sr_data_out
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       gnt;
  logic             accept;
  logic             sel;

  shift_seq_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  // Ready is also gated by reset so nothing looks acceptable while reset is asserted.
  assign req_ready = (state_q == S_IDLE && reset) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = gnt[1];

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= sanitize_op(sel ? req_op[5:3] : req_op[2:0]);
      cnt_q  <= sel ? req_cnt[2*CNT_W-1:CNT_W] : req_cnt[CNT_W-1:0];
      data_q <= sel ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rem_d      = rem_q;
    busy       = 1'b1;
    sr_enable  = 1'b0;
    sr_dir     = DIR_LOAD;
    sr_data_in = '0;
    rsp_valid  = 2'b00;
    rsp_data   = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          owner_d = sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sr_enable  = 1'b1;
        sr_data_in = data_q;
        if (op_q == DIR_LOAD || cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          rem_d   = cnt_q;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_enable = 1'b1;
        sr_dir    = op_q;
        rem_d     = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_data           = sr_data_out;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed and randomized checks of shift_seq_ctrl driving a real shift_reg2.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [5:0]  req_cnt;
  logic [15:0] req_data;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        sr_enable;
  logic [2:0]  sr_dir;
  logic [7:0]  sr_data_in;
  logic [7:0]  sr_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_cnt     (req_cnt),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .sr_enable   (sr_enable),
    .sr_dir      (sr_dir),
    .sr_data_in  (sr_data_in),
    .sr_data_out (sr_data_out)
  );

  shift_reg2 #(.WIDTH(8)) u_sr (
    .clk             (clk),
    .reset           (reset),
    .enable          (sr_enable),
    .shift_direction (sr_dir),
    .data_in         (sr_data_in),
    .data_out        (sr_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A requester may not drop valid while it is still waiting to be accepted.
  logic [1:0] pend_q = 2'b00;
  always @(posedge clk) begin
    if (!reset) begin
      pend_q <= 2'b00;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (pend_q[r]) begin
          n_tests++;
          assert (req_valid[r] === 1'b1) else begin
            n_fail++;
            $error("FAIL protocol_withdraw: observed %0b expected 1", req_valid[r]);
          end
        end
      end
      pend_q <= req_valid & ~req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Result of loading d and applying c shifts of kind op, computed arithmetically.
  function automatic logic [7:0] model(input logic [2:0] op, input int c, input logic [7:0] d);
    int v;
    v = int'(d);
    if (op == 3'd0 || op > 3'd4 || c == 0) return d;
    case (op)
      3'd1:    v = (v << c) & 255;
      3'd2:    v = v >> c;
      3'd3:    v = ((v << c) | (v >> (8 - c))) & 255;
      default: v = ((v >> c) | (v << (8 - c))) & 255;
    endcase
    return v[7:0];
  endfunction

  function automatic int model_lat(input logic [2:0] op, input int c);
    return (op == 3'd0 || op > 3'd4 || c == 0) ? 2 : c + 2;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(req_ready),  0);
    check({tag, "_rspv"},   32'(rsp_valid),  0);
    check({tag, "_rspd"},   32'(rsp_data),   0);
    check({tag, "_busy"},   32'(busy),       0);
    check({tag, "_sren"},   32'(sr_enable),  0);
    check({tag, "_srdir"},  32'(sr_dir),     0);
    check({tag, "_srdin"},  32'(sr_data_in), 0);
  endtask

  // Issue one command from requester r and check response owner, value, timing and activity.
  task automatic run_cmd(input int r, input logic [2:0] op, input logic [2:0] c,
                         input logic [7:0] d, input logic [7:0] exp_d, input string tag);
    bit got;
    int lat, en_cnt, busy_cnt;
    req_op[r*3 +: 3]   = op;
    req_cnt[r*3 +: 3]  = c;
    req_data[r*8 +: 8] = d;
    req_valid[r]       = 1'b1;
    #1;
    got = 0;
    for (int w = 0; w < 20; w++) begin
      if (req_ready == 2'(1 << r)) begin
        got = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check({tag, "_accepted"}, 32'(got), 1);
    if (!got) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    got = 0; en_cnt = 0; busy_cnt = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      en_cnt   += int'(sr_enable);
      busy_cnt += int'(busy);
      if (rsp_valid != 2'b00) begin
        got = 1;
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_rsp_seen"}, 32'(got), 1);
    check({tag, "_rsp_owner"}, 32'(rsp_valid), 32'(1 << r));
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
    check({tag, "_latency"}, 32'(lat), 32'(model_lat(op, int'(c))));
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(model_lat(op, int'(c)) - 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(model_lat(op, int'(c))));
    @(negedge clk);
    check({tag, "_idle_after"}, 32'({busy, rsp_valid, rsp_data}), 0);
  endtask

  initial begin
    int o, cyc, acc_n, prev_acc, refill;
    bit got, spur;
    logic [1:0] acc;
    logic [2:0] rop;
    logic [7:0] rd;
    logic [2:0] rc;
    int exp_owner[$];
    int exp_cyc[$];
    logic [7:0] exp_data[$];

    reset     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_cnt   = '0;
    req_data  = '0;
    #2;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a SHL x5 command.
    req_op[2:0] = 3'd1; req_cnt[2:0] = 3'd5; req_data[7:0] = 8'h5A; req_valid[0] = 1'b1;
    #1;
    got = 0;
    for (int w = 0; w < 10; w++) begin
      if (req_ready[0]) begin got = 1; break; end
      @(negedge clk); #1;
    end
    check("rst_mid_accept", 32'(got), 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_in_shift", 32'({busy, sr_enable}), 32'h3);
    req_valid = 2'b11;
    req_op    = {3'd1, 3'd1};
    req_cnt   = {3'd2, 3'd2};
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    spur = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy) spur = 1;
    end
    check("rst_no_rsp_after", 32'(spur), 0);

    // Both requesters continuously valid with cnt=2 commands.
    req_op   = {3'($urandom_range(1, 4)), 3'($urandom_range(1, 4))};
    req_data = 16'($urandom);
    req_valid = 2'b11;
    #1;
    check("rst_grant_req0", 32'(req_ready), 32'h1);
    cyc = 0; acc_n = 0; prev_acc = -1; refill = -1;
    for (int t = 0; t < 60; t++) begin
      if (rsp_valid != 2'b00) begin
        if (exp_owner.size() == 0) begin
          check("rr_spurious_rsp", 32'(rsp_valid), 0);
        end else begin
          o = exp_owner.pop_front();
          check("rr_rsp_owner", 32'(rsp_valid), 32'(1 << o));
          check("rr_rsp_data", 32'(rsp_data), 32'(exp_data.pop_front()));
          check("rr_rsp_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
        end
      end
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        check("rr_grant_order", 32'(acc), (acc_n % 2 == 0) ? 32'h1 : 32'h2);
        if (prev_acc >= 0) check("rr_spacing", 32'(cyc - prev_acc), 5);
        prev_acc = cyc;
        o = acc[1] ? 1 : 0;
        exp_owner.push_back(o);
        exp_data.push_back(model(req_op[o*3 +: 3], int'(req_cnt[o*3 +: 3]), req_data[o*8 +: 8]));
        exp_cyc.push_back(cyc + 4);
        acc_n++;
        refill = o;
      end
      if (acc_n == 4 && exp_owner.size() == 0) break;
      @(negedge clk);
      cyc++;
      if (refill >= 0) begin
        if (acc_n <= 2) begin
          req_op[refill*3 +: 3]   = 3'($urandom_range(1, 4));
          req_data[refill*8 +: 8] = 8'($urandom);
        end else begin
          req_valid[refill] = 1'b0;
        end
        refill = -1;
      end
      #1;
    end
    check("rr_accepts", 32'(acc_n), 4);
    check("rr_all_rsp", 32'(exp_owner.size()), 0);
    req_valid = 2'b00;
    @(negedge clk);

    // Directed commands.
    run_cmd(0, 3'd0, 3'd3, 8'hA5, 8'hA5, "load_a5");
    run_cmd(1, 3'd1, 3'd3, 8'h81, 8'h08, "shl3_81");
    run_cmd(1, 3'd4, 3'd1, 8'h01, 8'h80, "ror1_01");
    run_cmd(0, 3'd2, 3'd0, 8'h3C, 8'h3C, "shr0_3c");
    run_cmd(1, 3'd3, 3'd7, 8'h01, 8'h80, "rol7_01");
    run_cmd(0, 3'd6, 3'd4, 8'hC3, 8'hC3, "badop_c3");

    // Randomized commands against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      o   = int'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      rc  = 3'($urandom_range(0, 7));
      rd  = 8'($urandom);
      run_cmd(o, rop, rc, rd, model(rop, int'(rc), rd), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
